// File: rtl/shift_sequencer.sv
// Sequencer for an external universal shift register. It loads one parallel word,
// then shifts it out one bit at a time, either LSB-first or MSB-first, under a ready/valid handshake.
module shift_sequencer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_dir,
  input  logic         fill,
  output logic [1:0]   usr_load,
  output logic [N-1:0] usr_pin,
  output logic         usr_rsin,
  output logic         usr_lsin,
  input  logic [N-1:0] usr_q,
  output logic         ser_out,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] count_r, count_s;
  logic [N-1:0]  data_r;
  logic          dir_r;
  logic          fill_r;
  logic          capture_s;

  // State, bit count and the fields captured with each accepted word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      count_r <= '0;
      data_r  <= '0;
      dir_r   <= 1'b0;
      fill_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      if (capture_s) begin
        data_r <= in_data;
        dir_r  <= in_dir;
        fill_r <= fill;
      end
    end
  end

  // Both serial inputs carry the captured fill; fill_r is cleared by reset
  assign usr_rsin = fill_r;
  assign usr_lsin = fill_r;

  // Next-state and output decode; in SHIFT, usr_load follows ser_ready so a stall holds the register
  always_comb begin
    state_s   = state_r;
    count_s   = count_r;
    capture_s = 1'b0;
    in_ready  = 1'b0;
    usr_load  = 2'b00;
    usr_pin   = '0;
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          capture_s = 1'b1;
          count_s   = '0;
          state_s   = LOAD;
        end else begin
          state_s   = IDLE;
        end
      end
      LOAD: begin
        usr_load = 2'b11;
        usr_pin  = data_r;
        state_s  = SHIFT;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = dir_r ? usr_q[N-1] : usr_q[0];
        if (ser_ready) begin
          usr_load = dir_r ? 2'b10 : 2'b01;
          count_s  = count_r + ONE_C;
          if (count_r == LAST_C) begin
            state_s = DONE;
          end else begin
            state_s = SHIFT;
          end
        end else begin
          count_s = count_r;
          state_s = SHIFT;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_s = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer (N=4). It drives the sequencer into a
// behavioural 4-bit universal shift register and checks serial order, stalls, reset and back-to-back words.
module tb_shift_sequencer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_dir;
  logic       fill;
  logic [1:0] usr_load;
  logic [3:0] usr_pin;
  logic       usr_rsin;
  logic       usr_lsin;
  logic [3:0] usr_q;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_ready;
  logic       busy;
  logic       done;

  int n_cmp;
  int n_err;

  shift_sequencer #(.N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .fill      (fill),
    .usr_load  (usr_load),
    .usr_pin   (usr_pin),
    .usr_rsin  (usr_rsin),
    .usr_lsin  (usr_lsin),
    .usr_q     (usr_q),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached universal shift register: hold / right / left / parallel load
  always_ff @(posedge clk) begin
    case (usr_load)
      2'b01:   usr_q <= {usr_rsin, usr_q[3:1]};
      2'b10:   usr_q <= {usr_q[2:0], usr_lsin};
      2'b11:   usr_q <= usr_pin;
      default: usr_q <= usr_q;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One word from the IDLE cycle through DONE. exp_seq[3] is the first expected bit.
  task automatic run_word(input logic [3:0] d, input logic dr, input logic fl,
                          input logic [3:0] exp_seq, input logic [3:0] exp_q,
                          input int stall_at, input int stall_len,
                          input bit poke, input bit hold);
    logic [1:0] shift_code;
    shift_code = dr ? 2'b10 : 2'b01;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_dir = dr; fill = fl; ser_ready = 1'b1;
    #1;
    check("idle_ready", 32'(in_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_load", 32'(usr_load), 32'd0);
    @(negedge clk);
    in_valid = hold;
    if (!hold) begin
      in_data = ~d; in_dir = ~dr; fill = ~fl;
    end
    #1;
    check("load_mode", 32'(usr_load), 32'd3);
    check("load_pin", 32'(usr_pin), 32'(d));
    check("load_ready", 32'(in_ready), 32'd0);
    check("load_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (poke && i == 1) begin
        in_valid = 1'b1; in_data = 4'b0110; in_dir = ~dr;
      end else begin
        in_valid = hold;
      end
      if (i == stall_at) begin
        ser_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          #1;
          check("stall_load", 32'(usr_load), 32'd0);
          check("stall_bit", 32'(ser_out), 32'(exp_seq[3-i]));
          check("stall_valid", 32'(ser_valid), 32'd1);
          @(negedge clk);
        end
        ser_ready = 1'b1;
      end
      #1;
      check("bit_valid", 32'(ser_valid), 32'd1);
      check("bit_out", 32'(ser_out), 32'(exp_seq[3-i]));
      check("bit_mode", 32'(usr_load), 32'(shift_code));
      check("bit_ready", 32'(in_ready), 32'd0);
      check("bit_done", 32'(done), 32'd0);
      check("bit_pin", 32'(usr_pin), 32'd0);
    end
    @(negedge clk);
    in_valid = hold;
    #1;
    check("done_pulse", 32'(done), 32'd1);
    check("done_valid", 32'(ser_valid), 32'd0);
    check("done_load", 32'(usr_load), 32'd0);
    check("done_ready", 32'(in_ready), 32'd0);
    check("done_busy", 32'(busy), 32'd1);
    check("done_q", 32'(usr_q), 32'(exp_q));
    check("done_rsin", 32'(usr_rsin), 32'(fl));
    check("done_lsin", 32'(usr_lsin), 32'(fl));
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b0; in_valid = 1'b0; in_data = 4'b0000; in_dir = 1'b0;
    fill = 1'b0; ser_ready = 1'b1;
    #3;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_load", 32'(usr_load), 32'd0);
    check("rst_pin", 32'(usr_pin), 32'd0);
    check("rst_valid", 32'(ser_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rsin", 32'(usr_rsin), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // LSB-first with fill 0, then MSB-first with fill 1
    run_word(4'b1011, 1'b0, 1'b0, 4'b1101, 4'b0000, -1, 0, 1'b0, 1'b0);
    run_word(4'b1011, 1'b1, 1'b1, 4'b1011, 4'b1111, -1, 0, 1'b0, 1'b0);
    // two-cycle stall after the first bit
    run_word(4'b0110, 1'b0, 1'b1, 4'b0110, 4'b1111, 1, 2, 1'b0, 1'b0);
    // in_valid poked mid-shift must be ignored
    run_word(4'b1001, 1'b1, 1'b0, 4'b1001, 4'b0000, -1, 0, 1'b1, 1'b0);

    // Reset mid-word, after two accepted bits of 1100 (LSB-first, fill 0)
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'b1100; in_dir = 1'b0; fill = 1'b0; ser_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2;
    check("mid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(ser_valid), 32'd0);
    check("arst_load", 32'(usr_load), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_done", 32'(done), 32'd0);
    check("arst_rsin", 32'(usr_rsin), 32'd0);
    check("arst_q_kept", 32'(usr_q), 32'd3);
    @(negedge clk);
    #1;
    check("arst_no_done", 32'(done), 32'd0);
    check("arst_q_hold", 32'(usr_q), 32'd3);
    rst = 1'b1;
    run_word(4'b0101, 1'b1, 1'b0, 4'b0101, 4'b0000, -1, 0, 1'b0, 1'b0);

    // in_valid held across two consecutive words
    run_word(4'b1110, 1'b0, 1'b1, 4'b0111, 4'b1111, -1, 0, 1'b0, 1'b1);
    run_word(4'b0011, 1'b1, 1'b0, 4'b0011, 4'b0000, -1, 0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    check("end_done", 32'(done), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    check("end_ready", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
